cp0_vic: RTL
============

Name: cp0_vic

Overview:
- Parametrised successor to the single-cycle CP0: Status/Cause/EPC/Count/Compare plus IntCtl.
- Adds:
  - N synchronised external IRQ lines and two software IRQ bits.
  - EXL-based exception nesting and a Count prescaler.
  - Vectored interrupt dispatch with computed handler address.
- Sits beside the datapath. MFC0/MTC0 use (reg, sel) addressing. The pipeline commits exceptions via exc_take.

Parameters:
- NUM_EXT_IRQ, 5, external IRQ lines (1..5), mapped to IP2..IP(1+NUM_EXT_IRQ); IP7 reserved for timer.
- COUNT_DIV, 2, clk cycles per Count increment (>=1).
- EBASE, 32'h8000_0000, exception base; general vector EBASE+0x180, interrupt vectors EBASE+0x200+offset.
- SYNC_STAGES, 2, synchroniser depth on ext_irq (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ext_irq  in  NUM_EXT_IRQ  level-sensitive asynchronous interrupt requests
- cp0_we  in  1  MTC0 write strobe
- cp0_waddr  in  5  write register number
- cp0_wsel  in  3  write select
- cp0_wdata  in  32  write data
- cp0_raddr  in  5  read register number
- cp0_rsel  in  3  read select
- cp0_rdata  out  32  combinational read data
- pc  in  32  PC of faulting/interrupted instruction
- syscall, ri, overflow, divzero  in  1 each  synchronous exception flags
- eret  in  1  return from exception
- exc_take  in  1  pipeline commits the pending exception this cycle
- exc_pending  out  1  exception or unmasked interrupt requested
- exc_vector  out  32  handler address for the pending exception
- epc_out  out  32  current EPC (ERET target)

Behaviour:
- Register map, (reg, sel):
  - (9,0) Count.
  - (11,0) Compare.
  - (12,0) Status: IE[0], EXL[1], IM[15:8]; other bits read 0.
  - (12,1) IntCtl: VS[9:5] RW; IPTI[31:29] reads 7, read-only.
  - (13,0) Cause: ExcCode[6:2], IP[15:8], TI[30]. Only IP1:0 writable.
  - (14,0) EPC, RW.
  - Any other (reg, sel) reads 32'h0; writes to it are ignored.
- Reset values: all registers 0, prescaler 0, synchronisers 0, exc_pending 0, exc_vector EBASE+0x180.
- Count:
  - Prescaler counts 0..COUNT_DIV-1; Count increments when prescaler wraps; Count wraps 0xFFFF_FFFF->0.
  - MTC0 Count loads wdata and clears the prescaler; no increment that cycle.
- Timer:
  - TI set (sticky) on the cycle Count==Compare is registered.
  - MTC0 Compare clears TI. Clear wins over a simultaneous hit.
  - IP7 = TI.
- IRQ lines: ext_irq[k] passes through SYNC_STAGES flops and drives IP[2+k] directly (level, no latch). Latency from input to IP is SYNC_STAGES cycles.
- Request logic:
  - int_req = IE & ~EXL & |(IP & IM).
  - sync_exc = ri|syscall|overflow|divzero.
  - exc_pending = sync_exc | int_req.
- Priority and ExcCode:
  - Synchronous exceptions beat interrupts.
  - Among sync: ri (10) > syscall (8) > overflow (12) > divzero (15 — implementation-defined code; confirm against the handler's ExcCode table).
  - Interrupt ExcCode 0.
  - Synchronous exceptions are taken even when EXL=1.
- exc_vector:
  - ExcCode!=0, or VS==0: EBASE+0x180.
  - Interrupt with VS!=0: EBASE+0x200+n*VS*32, where n = highest set bit of IP&IM (7..0).
  - Arithmetic 32-bit, truncated.
- exc_take (rising clk, with exc_pending=1): EPC<=pc, EXL<=1, ExcCode<=selected code. exc_take with exc_pending=0 is ignored.
- eret: EXL<=0.
- Simultaneous events:
  - exc_take beats eret.
  - exc_take beats an MTC0 to Status/Cause/EPC in the same cycle, for the fields it updates.
  - MTC0 beats counter increment.
- Reset mid-operation: all state returns to reset values next edge; synchronisers flush.

Decomposition:
- Package cp0_pkg holds:
  - Register numbers: CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14; INTCTL sel=1.
  - ExcCode constants: INT=0, SYS=8, RI=10, OV=12, DZ=15.
  - Status/Cause bit-position constants.
- One natural sub-module: cp0_timer (prescaler, Count, Compare, TI), reused by future cores.

Test Plan:
- Reset, then read (12,0), (13,0), (14,0), (12,1) -> 0, 0, 0, 32'hE000_0000.
- COUNT_DIV=2: write Count=5, Compare=8 -> TI=1 and IP7=1 at 6 cycles after the write. MTC0 Compare=20 on the same cycle as a hit -> TI stays 0.
- Status=0x0000_0401 (IE, IM2), assert ext_irq[0] -> exc_pending=1 exactly SYNC_STAGES cycles later. exc_take with pc=0x100 -> EPC=0x100, EXL=1, ExcCode=0, exc_pending drops.
- VS=1, IM=0xFF, IE=1, ext_irq[0] and TI both pending -> exc_vector=EBASE+0x200+7*32=0x8000_02E0.
- EXL=1, syscall=1 -> exc_pending=1, vector 0x8000_0180. ri+syscall together -> ExcCode 10 after take. eret and exc_take in the same cycle -> EXL stays 1.
- Write (12,2) 0xFFFF_FFFF -> ignored; read (12,2) -> 0. MTC0 Cause 0xFFFF_FFFF -> only IP1:0 set.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and field positions.
// Imported by the interrupt controller and the reusable timer.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [2:0] SEL_MAIN   = 3'd0;
    localparam logic [2:0] SEL_INTCTL = 3'd1;

    typedef enum logic [4:0] {
        EXC_INT = 5'd0,
        EXC_SYS = 5'd8,
        EXC_RI  = 5'd10,
        EXC_OV  = 5'd12,
        EXC_DZ  = 5'd15
    } exc_code_e;

    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_IM_HI = 15;

    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_IP_LO  = 8;
    localparam int CA_IP_HI  = 15;
    localparam int CA_TI     = 30;

    localparam int IC_VS_LO   = 5;
    localparam int IC_VS_HI   = 9;
    localparam int IC_IPTI_LO = 29;
    localparam int IC_IPTI_HI = 31;

    localparam logic [2:0] IPTI_VALUE = 3'd7;
    localparam int         IP_TIMER   = 7;

    // Fixed priority among synchronous exceptions.
    function automatic exc_code_e sync_exc_code(input logic ri, input logic sys,
                                                input logic ov, input logic dz);
        if (ri)       return EXC_RI;
        else if (sys) return EXC_SYS;
        else if (ov)  return EXC_OV;
        else if (dz)  return EXC_DZ;
        else          return EXC_INT;
    endfunction

    function automatic logic [2:0] top_bit(input logic [7:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) n = 3'(i);
        end
        return n;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with clock prescaler and sticky terminal-count flag (TI).
// MTC0 Count restarts the prescaler; MTC0 Compare clears TI and wins over a hit.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    localparam int            PW      = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(COUNT_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [31:0]   r_count;
    logic [31:0]   r_compare;
    logic          r_ti;

    logic          w_tick;
    logic          w_count_upd;
    logic [31:0]   w_count_next;
    logic          w_hit;

    always_comb begin
        w_tick       = (r_presc == PRE_MAX);
        w_count_upd  = i_count_we | w_tick;
        w_count_next = r_count;
        if (i_count_we)  w_count_next = i_wdata;
        else if (w_tick) w_count_next = r_count + 32'd1;
        // Hit only when Count takes a new value, so a stalled Count cannot re-arm TI.
        w_hit = w_count_upd & (w_count_next == r_compare);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc   <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            if (i_count_we || w_tick) r_presc <= '0;
            else                      r_presc <= r_presc + PW'(1);
            r_count <= w_count_next;
            if (i_compare_we) begin
                r_compare <= i_wdata;
                r_ti      <= 1'b0;
            end else if (w_hit) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_vic.sv
// CP0 with synchronised external IRQs, EXL nesting and vectored interrupt dispatch.
// Reads are combinational; exc_take commits the currently selected exception.
module cp0_vic
    import cp0_pkg::*;
#(
    parameter int          NUM_EXT_IRQ = 5,
    parameter int          COUNT_DIV   = 2,
    parameter logic [31:0] EBASE       = 32'h8000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_EXT_IRQ-1:0] ext_irq,
    input  logic                   cp0_we,
    input  logic [4:0]             cp0_waddr,
    input  logic [2:0]             cp0_wsel,
    input  logic [31:0]            cp0_wdata,
    input  logic [4:0]             cp0_raddr,
    input  logic [2:0]             cp0_rsel,
    output logic [31:0]            cp0_rdata,
    input  logic [31:0]            pc,
    input  logic                   syscall,
    input  logic                   ri,
    input  logic                   overflow,
    input  logic                   divzero,
    input  logic                   eret,
    input  logic                   exc_take,
    output logic                   exc_pending,
    output logic [31:0]            exc_vector,
    output logic [31:0]            epc_out
);

    logic                   r_ie;
    logic                   r_exl;
    logic [7:0]             r_im;
    logic [4:0]             r_vs;
    logic [1:0]             r_ip_sw;
    exc_code_e              r_exc_code;
    logic [31:0]            r_epc;
    logic [NUM_EXT_IRQ-1:0] r_sync [SYNC_STAGES];

    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_intctl;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic [7:0]  w_ip;
    logic [7:0]  w_ip_active;
    logic        w_int_req;
    logic        w_sync_exc;
    exc_code_e   w_code;
    logic        w_take;
    logic [2:0]  w_top;
    logic [31:0] w_vec_int;
    logic [31:0] w_status;
    logic [31:0] w_intctl;
    logic [31:0] w_cause;

    always_comb begin
        w_wr_count   = cp0_we && (cp0_waddr == CP0_COUNT)   && (cp0_wsel == SEL_MAIN);
        w_wr_compare = cp0_we && (cp0_waddr == CP0_COMPARE) && (cp0_wsel == SEL_MAIN);
        w_wr_status  = cp0_we && (cp0_waddr == CP0_STATUS)  && (cp0_wsel == SEL_MAIN);
        w_wr_intctl  = cp0_we && (cp0_waddr == CP0_STATUS)  && (cp0_wsel == SEL_INTCTL);
        w_wr_cause   = cp0_we && (cp0_waddr == CP0_CAUSE)   && (cp0_wsel == SEL_MAIN);
        w_wr_epc     = cp0_we && (cp0_waddr == CP0_EPC)     && (cp0_wsel == SEL_MAIN);
    end

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_count_we   (w_wr_count),
        .i_compare_we (w_wr_compare),
        .i_wdata      (cp0_wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= ext_irq;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    always_comb begin
        w_ip      = '0;
        w_ip[1:0] = r_ip_sw;
        for (int k = 0; k < NUM_EXT_IRQ; k++) w_ip[2 + k] = r_sync[SYNC_STAGES-1][k];
        w_ip[IP_TIMER] = w_ti;
    end

    always_comb begin
        w_ip_active = w_ip & r_im;
        w_int_req   = r_ie & ~r_exl & (|w_ip_active);
        w_sync_exc  = ri | syscall | overflow | divzero;
        w_code      = sync_exc_code(ri, syscall, overflow, divzero);
        w_take      = exc_take & exc_pending;
        w_top       = top_bit(w_ip_active);
        w_vec_int   = EBASE + 32'h200 + ((32'(w_top) * 32'(r_vs)) << 5);
        exc_pending = w_sync_exc | w_int_req;
        // Only a taken-able interrupt with vectoring enabled leaves the general vector.
        if (!w_sync_exc && w_int_req && (r_vs != 5'd0)) exc_vector = w_vec_int;
        else                                            exc_vector = EBASE + 32'h180;
    end

    // Later assignments win: MTC0 < eret < exc_take.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ie       <= 1'b0;
            r_exl      <= 1'b0;
            r_im       <= '0;
            r_vs       <= '0;
            r_ip_sw    <= '0;
            r_exc_code <= EXC_INT;
            r_epc      <= '0;
        end else begin
            if (w_wr_status) begin
                r_ie  <= cp0_wdata[ST_IE];
                r_exl <= cp0_wdata[ST_EXL];
                r_im  <= cp0_wdata[ST_IM_HI:ST_IM_LO];
            end
            if (w_wr_intctl) r_vs    <= cp0_wdata[IC_VS_HI:IC_VS_LO];
            if (w_wr_cause)  r_ip_sw <= cp0_wdata[CA_IP_LO+1:CA_IP_LO];
            if (w_wr_epc)    r_epc   <= cp0_wdata;
            if (eret)        r_exl   <= 1'b0;
            if (w_take) begin
                r_epc      <= pc;
                r_exl      <= 1'b1;
                r_exc_code <= w_code;
            end
        end
    end

    always_comb begin
        w_status                    = '0;
        w_status[ST_IE]             = r_ie;
        w_status[ST_EXL]            = r_exl;
        w_status[ST_IM_HI:ST_IM_LO] = r_im;

        w_intctl                        = '0;
        w_intctl[IC_VS_HI:IC_VS_LO]     = r_vs;
        w_intctl[IC_IPTI_HI:IC_IPTI_LO] = IPTI_VALUE;

        w_cause                       = '0;
        w_cause[CA_EXC_HI:CA_EXC_LO]  = r_exc_code;
        w_cause[CA_IP_HI:CA_IP_LO]    = w_ip;
        w_cause[CA_TI]                = w_ti;
    end

    always_comb begin
        cp0_rdata = '0;
        if (cp0_rsel == SEL_MAIN) begin
            case (cp0_raddr)
                CP0_COUNT:   cp0_rdata = w_count;
                CP0_COMPARE: cp0_rdata = w_compare;
                CP0_STATUS:  cp0_rdata = w_status;
                CP0_CAUSE:   cp0_rdata = w_cause;
                CP0_EPC:     cp0_rdata = r_epc;
                default:     cp0_rdata = '0;
            endcase
        end else if ((cp0_rsel == SEL_INTCTL) && (cp0_raddr == CP0_STATUS)) begin
            cp0_rdata = w_intctl;
        end
    end

    assign epc_out = r_epc;

endmodule
